// File: rtl/keypad_entry_display.sv
// Qualifies the keypad decoder's key-present flag into one event per press, shifts accepted
// hex digits into a 4-digit entry register and multiplexes it onto a common-anode 4-digit SSD.
module keypad_entry_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RELEASE_CYCLES  = 500_000,
  parameter int unsigned REFRESH_CYCLES  = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_pressed,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_value,
  output logic [15:0] disp_value,
  output logic [2:0]  digit_count,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
  localparam int unsigned FW = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PEND, HELD} state_t;

  state_t          state;
  logic [3:0]      cap;
  logic [DW-1:0]   cnt;
  logic [RW-1:0]   rel_cnt;
  logic [FW-1:0]   ref_cnt;
  logic [1:0]      idx;
  logic            held_c;
  logic            code_change_c;
  logic            accept_c;
  logic [3:0]      digit_c;

  // The flag is only high while the key's column is scanned; stretch it across scan gaps.
  assign held_c        = key_pressed | (rel_cnt != '0);
  assign code_change_c = key_pressed & (key_code != cap);
  assign accept_c      = (state == PEND) & ~code_change_c & held_c &
                         (cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign digit_c       = disp_value[{idx, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_cnt <= '0;
    end else if (key_pressed) begin
      rel_cnt <= RW'(RELEASE_CYCLES);
    end else if (rel_cnt != '0) begin
      rel_cnt <= rel_cnt - RW'(1);
    end
  end

  // Press qualifier: one accepted event per press, release required before the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cap       <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_value <= '0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (key_pressed) begin
            state <= PEND;
            cap   <= key_code;
            cnt   <= '0;
          end
        end
        PEND: begin
          if (code_change_c) begin
            cap <= key_code;
            cnt <= '0;
          end else if (!held_c) begin
            state <= IDLE;
          end else if (accept_c) begin
            state     <= HELD;
            key_valid <= 1'b1;
            key_value <= cap;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        HELD: begin
          if (!held_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry register; clear takes priority over a same-cycle accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_value  <= '0;
      digit_count <= '0;
    end else if (clear) begin
      disp_value  <= '0;
      digit_count <= '0;
    end else if (accept_c) begin
      disp_value <= {disp_value[11:0], cap};
      if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
    end
  end

  // Digit multiplexer; digit 0 always lit so an empty entry shows "0".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
    end else begin
      if (ref_cnt == FW'(REFRESH_CYCLES - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + FW'(1);
      end
      if ((idx == 2'd0) || ({1'b0, idx} < digit_count)) begin
        an <= ~(4'b0001 << idx);
      end else begin
        an <= 4'b1111;
      end
      seg <= hex7(digit_c);
    end
  end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display with short debounce/release/refresh windows.
module tb_keypad_entry_display;

  // Debounce longer than the release window so a short blip times out before acceptance.
  localparam int unsigned DEB = 32;
  localparam int unsigned REL = 20;
  localparam int unsigned REF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_value;
  logic [15:0] disp_value;
  logic [2:0]  digit_count;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;
  int kv_count = 0;

  keypad_entry_display #(
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_value  (key_value),
    .disp_value (disp_value),
    .digit_count(digit_count),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (key_valid === 1'b1) kv_count = kv_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c, input int hi, input int lo);
    key_code    = c;
    key_pressed = 1'b1;
    repeat (hi) tick();
    key_pressed = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    int kv0;
    rst = 1'b0; key_code = '0; key_pressed = 1'b0; clear = 1'b0;
    repeat (3) tick();
    n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL rst_an got=%b exp=1111", an); end
    n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL rst_seg got=%b exp=1111111", seg); end
    n_cmp++; if ({key_valid, key_value, disp_value, digit_count} !== 24'h0) begin
      n_bad++; $display("FAIL rst_regs got=%b/%h/%h/%0d exp=0", key_valid, key_value, disp_value, digit_count);
    end
    rst = 1'b1;
    press(4'h3, 40, 30);
    n_cmp++; if (disp_value !== 16'h0003) begin n_bad++; $display("FAIL pre_rst_disp got=%h exp=0003", disp_value); end
    key_code = 4'h4; key_pressed = 1'b1;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL midrst_an got=%b exp=1111", an); end
    n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL midrst_seg got=%b exp=1111111", seg); end
    n_cmp++; if ({key_valid, key_value, disp_value, digit_count} !== 24'h0) begin
      n_bad++; $display("FAIL midrst_regs got=%b/%h/%h/%0d exp=0", key_valid, key_value, disp_value, digit_count);
    end
    key_pressed = 1'b0;
    repeat (3) tick();
    kv0 = kv_count;
    rst = 1'b1;
    repeat (40) tick();
    n_cmp++; if (kv_count !== kv0) begin n_bad++; $display("FAIL rst_drop_kv got=%0d exp=%0d", kv_count, kv0); end
    n_cmp++; if (disp_value !== 16'h0) begin n_bad++; $display("FAIL rst_drop_disp got=%h exp=0000", disp_value); end
  endtask

  task automatic test_scan_press();
    int kv0 = kv_count;
    key_code = 4'h5;
    for (int i = 0; i < 64; i++) begin
      key_pressed = ((i % 16) < 3);
      tick();
    end
    key_pressed = 1'b0;
    repeat (40) tick();
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL scan_kv got=%0d exp=1", kv_count - kv0); end
    n_cmp++; if (key_value !== 4'h5) begin n_bad++; $display("FAIL scan_val got=%h exp=5", key_value); end
    n_cmp++; if (disp_value !== 16'h0005) begin n_bad++; $display("FAIL scan_disp got=%h exp=0005", disp_value); end
    n_cmp++; if (digit_count !== 3'd1) begin n_bad++; $display("FAIL scan_cnt got=%0d exp=1", digit_count); end
  endtask

  task automatic test_bounce();
    int kv0 = kv_count;
    press(4'h6, 2, 30);
    n_cmp++; if (kv_count !== kv0) begin n_bad++; $display("FAIL bounce_kv got=%0d exp=%0d", kv_count, kv0); end
    n_cmp++; if (disp_value !== 16'h0005) begin n_bad++; $display("FAIL bounce_disp got=%h exp=0005", disp_value); end
    n_cmp++; if (key_value !== 4'h5) begin n_bad++; $display("FAIL bounce_val got=%h exp=5", key_value); end
  endtask

  task automatic test_multi();
    logic [3:0] keys [5];
    logic [3:0] ea [4];
    logic [6:0] es [4];
    logic [3:0] prev;
    int kv0 = kv_count;
    int w = 0;
    keys = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
    ea   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es   = '{7'b0001000, 7'b0011001, 7'b0110000, 7'b0100100};
    for (int k = 0; k < 5; k++) press(keys[k], 40, 30);
    n_cmp++; if (kv_count - kv0 !== 5) begin n_bad++; $display("FAIL multi_kv got=%0d exp=5", kv_count - kv0); end
    n_cmp++; if (disp_value !== 16'h234A) begin n_bad++; $display("FAIL multi_disp got=%h exp=234a", disp_value); end
    n_cmp++; if (digit_count !== 3'd4) begin n_bad++; $display("FAIL multi_cnt got=%0d exp=4", digit_count); end
    prev = an;
    while (!(an == 4'b1110 && prev != 4'b1110) && w < 40) begin prev = an; tick(); w++; end
    n_cmp++; if (w >= 40) begin n_bad++; $display("FAIL multi_sync got=timeout exp=an 1110"); end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        if (p != 0 || c != 0) tick();
        n_cmp++; if (an !== ea[p]) begin n_bad++; $display("FAIL multi_an%0d got=%b exp=%b", p, an, ea[p]); end
        n_cmp++; if (seg !== es[p]) begin n_bad++; $display("FAIL multi_seg%0d got=%b exp=%b", p, seg, es[p]); end
      end
    end
  endtask

  task automatic test_code_switch();
    int kv0 = kv_count;
    key_code = 4'h7; key_pressed = 1'b1;
    tick();
    repeat (4) tick();
    key_code = 4'h9;
    repeat (40) tick();
    key_pressed = 1'b0;
    repeat (30) tick();
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL switch_kv got=%0d exp=1", kv_count - kv0); end
    n_cmp++; if (key_value !== 4'h9) begin n_bad++; $display("FAIL switch_val got=%h exp=9", key_value); end
    n_cmp++; if (disp_value !== 16'h34A9) begin n_bad++; $display("FAIL switch_disp got=%h exp=34a9", disp_value); end
  endtask

  task automatic test_clear();
    logic [3:0] ea [4];
    logic [6:0] es [2];
    logic [3:0] prev;
    int w = 0;
    ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    es = '{7'b0100100, 7'b1111001};
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (disp_value !== 16'h0 || digit_count !== 3'd0) begin
      n_bad++; $display("FAIL clr_pulse got=%h/%0d exp=0000/0", disp_value, digit_count);
    end
    key_code = 4'h8; key_pressed = 1'b1;
    tick();
    repeat (DEB - 1) tick();
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL clr_pre_kv got=%b exp=0", key_valid); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL clr_acc_kv got=%b exp=1", key_valid); end
    n_cmp++; if (key_value !== 4'h8) begin n_bad++; $display("FAIL clr_acc_val got=%h exp=8", key_value); end
    n_cmp++; if (disp_value !== 16'h0 || digit_count !== 3'd0) begin
      n_bad++; $display("FAIL clr_acc_disp got=%h/%0d exp=0000/0", disp_value, digit_count);
    end
    tick();
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL clr_kv_pulse got=%b exp=0", key_valid); end
    key_pressed = 1'b0;
    repeat (30) tick();
    press(4'h1, 40, 30);
    press(4'h2, 40, 30);
    n_cmp++; if (disp_value !== 16'h0012) begin n_bad++; $display("FAIL clr_disp got=%h exp=0012", disp_value); end
    n_cmp++; if (digit_count !== 3'd2) begin n_bad++; $display("FAIL clr_cnt got=%0d exp=2", digit_count); end
    prev = an;
    while (!(an == 4'b1110 && prev != 4'b1110) && w < 40) begin prev = an; tick(); w++; end
    n_cmp++; if (w >= 40) begin n_bad++; $display("FAIL clr_sync got=timeout exp=an 1110"); end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        if (p != 0 || c != 0) tick();
        n_cmp++; if (an !== ea[p]) begin n_bad++; $display("FAIL clr_an%0d got=%b exp=%b", p, an, ea[p]); end
        if (p < 2) begin
          n_cmp++; if (seg !== es[p]) begin n_bad++; $display("FAIL clr_seg%0d got=%b exp=%b", p, seg, es[p]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_press();
    test_bounce();
    test_multi();
    test_code_switch();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
